// File: rtl/fifo_defs.sv
// -----------------------------------------------------------------------------
// fifo_defs
//   Shared definitions for the extended synchronous FIFO.
//   - FWFT_MODE / REG_MODE : read-mode selector values for the FWFT parameter
//   - clog2()              : ceiling log2 usable in constant expressions
//   - is_pow2()            : power-of-two test
//   - params_ok()          : combined legality check of the FIFO parameters,
//                            evaluated at elaboration time by the top level
// -----------------------------------------------------------------------------
package fifo_defs;

    localparam bit FWFT_MODE = 1'b1;
    localparam bit REG_MODE  = 1'b0;

    // Ceiling log2; clog2(1) == 0, clog2(16) == 4, clog2(17) == 5.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 32'd0;
        rem    = (value == 32'd0) ? 32'd0 : value - 32'd1;
        for (int i = 0; i < 32; i++) begin
            if (rem != 32'd0) begin
                result = result + 32'd1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

    function automatic bit params_ok(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned af_thresh,
        input int unsigned ae_thresh
    );
        return (width >= 32'd1) &&
               (depth >= 32'd2) && is_pow2(depth) &&
               (af_thresh >= 32'd1) && (af_thresh <= depth) &&
               (ae_thresh <= depth - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   DEPTH x WIDTH storage array for fifo_sync_ext. One synchronous write port,
//   one asynchronous (combinational) read port. Contents are deliberately not
//   reset: the FIFO tracks validity through its pointers and count.
//
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, mem[raddr_i]
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_defs::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_ext.sv
// -----------------------------------------------------------------------------
// fifo_sync_ext
//   Synchronous FIFO buffering bytes between the host writer and the UART TX
//   shifter. Adds FWFT or registered read mode, a fill-level count,
//   programmable almost-full/almost-empty flags, synchronous flush and sticky
//   overflow/underflow error flags.
//
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   flush         in   synchronous clear of pointers, count and error flags
//   wr_en         in   write request
//   data_in       in   write data
//   rd_en         in   read (pop) request
//   data_out      out  FWFT=1: head entry; FWFT=0: registered read data
//   data_valid    out  FWFT=0: one-cycle pulse on read data update; 0 if FWFT=1
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   count         out  number of entries held
//   overflow      out  sticky: a write was dropped
//   underflow     out  sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_ext
    import fifo_defs::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = FWFT_MODE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        data_out,
    output logic                    data_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_C   = PW'(1);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    // Reject illegal parameter sets at elaboration
    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
        $error("fifo_sync_ext: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH");
    end

    // Registered state
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             dvalid_q, dvalid_d;

    // Decoded status and handshakes
    logic             empty_s;
    logic             full_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic             ram_we_s;
    logic [WIDTH-1:0] ram_rdata_s;

    assign empty_s  = (count_q == ZERO_C);
    assign full_s   = (count_q == DEPTH_C);
    assign rd_acc_s = rd_en && !empty_s;
    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign wr_acc_s = wr_en && (!full_s || rd_acc_s);
    // flush wins over a concurrent write; storage is left untouched.
    assign ram_we_s = wr_acc_s && !flush;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata_s)
    );

    // Next-state computation for pointers, count, error flags and read register
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;

        if (flush) begin
            wr_ptr_d = ZERO_C;
            rd_ptr_d = ZERO_C;
            count_d  = ZERO_C;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            dvalid_d = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (rd_acc_s) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
                dout_d   = ram_rdata_s;
                dvalid_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
                dout_d   = dout_q;
                dvalid_d = 1'b0;
            end

            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase

            // A write with rd_en alongside while full is a pass-through, not a drop.
            if (wr_en && full_s && !rd_en) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end

            if (rd_en && empty_s) begin
                udf_d = 1'b1;
            end else begin
                udf_d = udf_q;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= ZERO_C;
            rd_ptr_q <= ZERO_C;
            count_q  <= ZERO_C;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= {WIDTH{1'b0}};
            dvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign data_out     = (FWFT == FWFT_MODE) ? ram_rdata_s : dout_q;
    assign data_valid   = (FWFT == FWFT_MODE) ? 1'b0 : dvalid_q;

endmodule

// File: doc/fifo_sync_ext.md
# fifo_sync_ext

Parametrised synchronous FIFO for the UART transmit path, buffering bytes between the host-side writer and the TX shifter. Compared with the plain sync FIFO it adds selectable first-word-fall-through or registered read mode, a fill-level count, programmable almost-full/almost-empty flags, a synchronous flush and sticky overflow/underflow error flags.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 16: number of entries; must be a power of two, ≥2.
- AF_THRESH, 12: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- FWFT, 1: 1 = first-word-fall-through read; 0 = registered read.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- data_in  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- data_out  out  WIDTH  read data.
- data_valid  out  1  FWFT=0 only: one-cycle pulse, data_out updated; tied 0 when FWFT=1.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit; the low bits index storage. Both wrap naturally modulo 2·DEPTH.
- count is a register, not derived from the pointers. It updates by +1 (write only), −1 (read only) or 0 (both or neither).
- Read accepted: rd_en && !empty.
- Write accepted: wr_en && (!full || read accepted). A write while full succeeds if a read is accepted in the same cycle; count stays at DEPTH.
- Simultaneous rd_en and wr_en while empty: the write is accepted, the read is rejected, and underflow is set.
- overflow sets when wr_en && full && !rd_en. underflow sets when rd_en && empty. Both hold until flush or rst.
- FWFT=1: data_out combinationally shows the head entry mem[rd_ptr]. It is valid whenever !empty and undefined when empty; the bench must not check it then. Asserting rd_en advances to the next entry.
- FWFT=0: on an accepted read, data_out registers the head entry and data_valid pulses for one cycle. Otherwise data_out holds its value.
- flush takes priority over wr_en and rd_en in the same cycle. It zeroes both pointers, count, overflow, underflow and data_valid. data_out holds its value. Storage contents are not cleared.
- rst (async) gives: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AF_THRESH ≥ 1), overflow 0, underflow 0, data_valid 0, data_out 0 in FWFT=0 mode. Storage is not reset.
- Reset asserted mid-transfer discards all contents. The first accepted write after rst deasserts lands in entry 0.

## Timing
- All flags and count are decoded combinationally from registered state, so they change only just after a clock edge.
- Write→read latency, FWFT=1: a write at edge N makes empty drop and data_out valid after edge N.
- FWFT=0: rd_en sampled at edge N gives data_out and data_valid after edge N, one cycle of read latency.
- full, empty, almost_* and count update after the same edge that moves the pointers.
- There is no combinational path from wr_en/rd_en to any output, except data_out in FWFT=1 via rd_ptr, which is registered.

## Structure
- Shared package/include fifo_defs: clog2 function, FWFT_MODE/REG_MODE localparams, and elaboration-time parameter checks (DEPTH power of two, threshold ranges).
- One sub-module, fifo_ram: DEPTH×WIDTH storage with one synchronous write port and one asynchronous read port. The top level holds pointers, count, flags and the output register.

## Test plan
- Defaults, FWFT=1: write 0x01..0x10 (16 words) → full=1, count=16, almost_full from the 12th write. Read 16 → data 0x01..0x10 in order, then empty=1, almost_empty from count=2.
- Full with rd_en+wr_en of 0xAA → full stays 1, count=16, overflow=0. Wr_en alone while full → overflow=1 and it stays set.
- Empty with rd_en+wr_en of 0x55 → count=1, underflow=1, data_out=0x55 next cycle (FWFT=1).
- FWFT=0: write 0x3C, pulse rd_en → data_out=0x3C and data_valid=1 one cycle later. data_out holds 0x3C after data_valid drops.
- Fill 5 words, assert flush together with wr_en → count=0, empty=1, overflow/underflow cleared, the write is dropped. Next write 0x77 is read back as 0x77.
- Fill 9 words, assert rst asynchronously mid-cycle → all outputs at reset values immediately. Wrap test: 40 interleaved write/read pairs → in-order data across pointer wrap.
